shift_cmd_seq: RTL and testbench

- Upstream command sequencer for the 8-bit shifter stage (shifter8).
- Accepts one shift command per valid/ready handshake.
- Drives shifter8's op/shamt/d_in for one LOAD cycle, then a programmable number of shift cycles.
- Captures shifter8's d_out and returns it through a valid/ready result port.
- Sits between the control logic and shifter8; shifter8's registered output is its only feedback.

---
 rtl/shift_cmd_seq_if.sv | 27 ++
 rtl/shift_cmd_seq.sv | 88 ++++++++
 tb/tb_shift_cmd_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/shift_cmd_seq_if.sv
// Command, shifter-drive and result bundle between control logic, the sequencer and shifter8.
interface shift_cmd_seq_if #(parameter int REPS_W = 4);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [1:0]        cmd_shamt;
    logic [REPS_W-1:0] cmd_reps;
    logic [7:0]        cmd_data;
    logic [2:0]        sh_op;
    logic [1:0]        sh_shamt;
    logic [7:0]        sh_d_in;
    logic [7:0]        sh_d_out;
    logic              res_valid;
    logic              res_ready;
    logic [7:0]        res_data;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_shamt, cmd_reps, cmd_data, sh_d_out, res_ready,
        input  cmd_ready, sh_op, sh_shamt, sh_d_in, res_valid, res_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_shamt, cmd_reps, cmd_data, sh_d_out, res_ready,
        output cmd_ready, sh_op, sh_shamt, sh_d_in, res_valid, res_data, busy
    );
endinterface

// File: rtl/shift_cmd_seq.sv
// Sequences one LOAD plus N shift cycles into shifter8 per accepted command and
// returns the shifter's registered output through a valid/ready result port.
module shift_cmd_seq #(
    parameter int REPS_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    shift_cmd_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPTURE, HOLD} state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LSL  = 3'b010;
    localparam logic [2:0] OP_LSR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;

    state_t            state, state_nxt;
    logic [1:0]        op_q;
    logic [1:0]        shamt_q;
    logic [REPS_W-1:0] reps_q;
    logic [REPS_W-1:0] cnt;
    logic [7:0]        data_q;
    logic [7:0]        res_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= '0;
            shamt_q <= '0;
            reps_q  <= '0;
            cnt     <= '0;
            data_q  <= '0;
            res_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    op_q    <= bus.cmd_op;
                    shamt_q <= bus.cmd_shamt;
                    // load-only commands never shift, whatever reps says
                    reps_q  <= (bus.cmd_op == 2'd3) ? '0 : bus.cmd_reps;
                    data_q  <= bus.cmd_data;
                end
                LOAD:    cnt   <= reps_q;
                SHIFT:   cnt   <= cnt - 1'b1;
                CAPTURE: res_q <= bus.sh_d_out;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.sh_op     = OP_NOP;
        bus.res_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) state_nxt = LOAD;
            end
            LOAD: begin
                bus.sh_op = OP_LOAD;
                state_nxt = (reps_q == '0) ? CAPTURE : SHIFT;
            end
            SHIFT: begin
                case (op_q)
                    2'd0:    bus.sh_op = OP_LSL;
                    2'd1:    bus.sh_op = OP_LSR;
                    default: bus.sh_op = OP_ASR;
                endcase
                if (cnt == REPS_W'(1)) state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = HOLD;
            HOLD: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.sh_shamt = shamt_q;
    assign bus.sh_d_in  = data_q;
    assign bus.res_data = res_q;
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_shift_cmd_seq.sv
// Directed bench for shift_cmd_seq driving a behavioural shifter8 model.
module tb_shift_cmd_seq;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    shift_cmd_seq_if #(.REPS_W(4)) bus ();

    shift_cmd_seq #(.REPS_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // shifter8 reference: registered output, reset_n = ~reset
    logic [7:0] sh_reg;
    always_ff @(posedge clk) begin
        if (reset) sh_reg <= 8'h00;
        else case (bus.sh_op)
            3'b001:  sh_reg <= bus.sh_d_in;
            3'b010:  sh_reg <= sh_reg << bus.sh_shamt;
            3'b011:  sh_reg <= sh_reg >> bus.sh_shamt;
            3'b100:  sh_reg <= 8'($signed(sh_reg) >>> bus.sh_shamt);
            default: sh_reg <= sh_reg;
        endcase
    end
    assign bus.sh_d_out = sh_reg;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one command and follow it through to HOLD; optionally release the result.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [1:0] shamt,
                           input logic [3:0] reps, input logic [7:0] data,
                           input logic [2:0] exp_shop, input int exp_shifts,
                           input logic [7:0] exp_res, input bit release_res);
        int lat;
        int nsh;
        check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_op    = op;
        bus.cmd_shamt = shamt;
        bus.cmd_reps  = reps;
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = ~data;
        bus.cmd_op    = 2'd0;
        bus.cmd_reps  = 4'd7;
        lat = 1;
        check({tag, "_load_op"}, 32'(bus.sh_op), 32'd1);
        check({tag, "_load_din"}, 32'(bus.sh_d_in), 32'(data));
        tick();
        lat++;
        nsh = 0;
        while (bus.sh_op == exp_shop && nsh < 40) begin
            check({tag, "_shamt"}, 32'(bus.sh_shamt), 32'(shamt));
            nsh++;
            tick();
            lat++;
        end
        check({tag, "_nshifts"}, 32'(nsh), 32'(exp_shifts));
        check({tag, "_cap_op"}, 32'(bus.sh_op), 32'd0);
        check({tag, "_cap_valid"}, 32'(bus.res_valid), 32'd0);
        tick();
        lat++;
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_shifts + 3));
        check({tag, "_res_data"}, 32'(bus.res_data), 32'(exp_res));
        if (release_res) begin
            bus.res_ready = 1'b1;
            tick();
            bus.res_ready = 1'b0;
            check({tag, "_rel_valid"}, 32'(bus.res_valid), 32'd0);
            check({tag, "_rel_ready"}, 32'(bus.cmd_ready), 32'd1);
            check({tag, "_rel_busy"}, 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_shamt = 2'd0;
        bus.cmd_reps  = 4'd0;
        bus.cmd_data  = 8'h00;
        bus.res_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_sh_op", 32'(bus.sh_op), 32'd0);
        check("rst_shamt", 32'(bus.sh_shamt), 32'd0);
        check("rst_d_in", 32'(bus.sh_d_in), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        run_cmd("loadonly", 2'd3, 2'd1, 4'd5, 8'hB7, 3'b111, 0, 8'hB7, 1'b1);
        run_cmd("lsl", 2'd0, 2'd1, 4'd2, 8'hB8, 3'b010, 2, 8'hE0, 1'b1);
        run_cmd("lsr", 2'd1, 2'd2, 4'd1, 8'h97, 3'b011, 1, 8'h25, 1'b1);
        run_cmd("asr", 2'd2, 2'd2, 4'd2, 8'h97, 3'b100, 2, 8'hF9, 1'b0);

        // backpressure on the ASR result; a competing command must be ignored
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 8'h11;
        bus.cmd_reps  = 4'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_res_data", 32'(bus.res_data), 32'hF9);
            check("bp_res_valid", 32'(bus.res_valid), 32'd1);
            check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check("bp_sh_op", 32'(bus.sh_op), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("bp_rel_valid", 32'(bus.res_valid), 32'd0);
        check("bp_rel_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        check("bp_idle_op", 32'(bus.sh_op), 32'd0);
        check("bp_idle_busy", 32'(bus.busy), 32'd0);

        run_cmd("maxreps", 2'd0, 2'd0, 4'd15, 8'h5A, 3'b010, 15, 8'h5A, 1'b1);

        // reset during the third shift cycle abandons the command
        bus.cmd_op    = 2'd0;
        bus.cmd_shamt = 2'd1;
        bus.cmd_reps  = 4'd10;
        bus.cmd_data  = 8'h01;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_shift_op", 32'(bus.sh_op), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_op", 32'(bus.sh_op), 32'd0);
        check("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_rst_quiet", 32'(bus.res_valid), 32'd0);
        end

        run_cmd("after_rst", 2'd0, 2'd3, 4'd1, 8'h03, 3'b010, 1, 8'h18, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
